// File: rtl/spi_flash_reader.sv
// Sequential SPI mode-0 reader for the configuration flash: one byte per continue request.
// Optional FLASH_FAST_READ_EN: fast-read opcode 8'h0B with 8 dummy clocks before data.
module spi_flash_reader #(
  parameter int unsigned CLK_DIV     = 2,
  parameter logic [15:0] ADDR_LO     = 16'h0,
  parameter int unsigned CS_HOLD_CYC = 4
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       FLASH_enable,
  input  logic [7:0] FLASH_sector,
  input  logic       FLASH_continue,
  output logic [7:0] FLASH_data,
  output logic       FLASH_busy,
  output logic       flash_ncs,
  output logic       flash_sck,
  output logic       flash_mosi,
  input  logic       flash_miso
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HOLD_W = (CS_HOLD_CYC > 1) ? $clog2(CS_HOLD_CYC) : 1;
  localparam int unsigned BIT_W  = 5;
`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] OPCODE = 8'h0B;
`else
  localparam logic [7:0] OPCODE = 8'h03;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_CMD,
    S_DUMMY,
    S_READ,
    S_VALID,
    S_CS_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [7:0]         sector_q, sector_d;
  logic [7:0]         shreg_q, shreg_d;
  logic [7:0]         data_q, data_d;
  logic               busy_q, busy_d;
  logic               ncs_q, ncs_d;
  logic               sck_q, sck_d;
  logic               mosi_q, mosi_d;

  logic               phase_end;
  logic               abort;
  logic [31:0]        cmd_word;

  assign phase_end = (div_q == DIV_W'(CLK_DIV - 1));
  assign abort     = !FLASH_enable && (state_q != S_IDLE) && (state_q != S_CS_HOLD);
  assign cmd_word  = {OPCODE, sector_q, ADDR_LO};

  assign FLASH_data = data_q;
  assign FLASH_busy = busy_q;
  assign flash_ncs  = ncs_q;
  assign flash_sck  = sck_q;
  assign flash_mosi = mosi_q;

  // State and datapath registers
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      hold_q   <= '0;
      sector_q <= '0;
      shreg_q  <= '0;
      data_q   <= 8'hFF;
      busy_q   <= 1'b1;
      ncs_q    <= 1'b1;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      hold_q   <= hold_d;
      sector_q <= sector_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      ncs_q    <= ncs_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
    end
  end

  // Next-state and next-output logic; every bit is a low phase then a high phase
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    hold_d   = hold_q;
    sector_d = sector_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    busy_d   = busy_q;
    ncs_d    = ncs_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b1;
        ncs_d  = 1'b1;
        sck_d  = 1'b0;
        mosi_d = 1'b0;
        div_d  = '0;
        bit_d  = '0;
        if (FLASH_enable) begin
          sector_d = FLASH_sector;
          ncs_d    = 1'b0;
          state_d  = S_CS_SETUP;
        end
      end

      S_CS_SETUP: begin
        div_d = div_q + DIV_W'(1);
        if (phase_end) begin
          div_d   = '0;
          bit_d   = '0;
          mosi_d  = OPCODE[7];
          state_d = S_CMD;
        end
      end

      S_CMD: begin
        div_d = div_q + DIV_W'(1);
        if (phase_end) begin
          div_d = '0;
          sck_d = ~sck_q;
          if (sck_q) begin
            if (bit_q == BIT_W'(31)) begin
              bit_d  = '0;
              mosi_d = 1'b0;
`ifdef FLASH_FAST_READ_EN
              state_d = S_DUMMY;
`else
              state_d = S_READ;
`endif
            end else begin
              bit_d  = bit_q + BIT_W'(1);
              mosi_d = cmd_word[5'd30 - bit_q];
            end
          end
        end
      end

`ifdef FLASH_FAST_READ_EN
      S_DUMMY: begin
        div_d = div_q + DIV_W'(1);
        if (phase_end) begin
          div_d = '0;
          sck_d = ~sck_q;
          if (sck_q) begin
            if (bit_q == BIT_W'(7)) begin
              bit_d   = '0;
              state_d = S_READ;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
        end
      end
`endif

      S_READ: begin
        div_d = div_q + DIV_W'(1);
        if (phase_end) begin
          div_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            shreg_d = {shreg_q[6:0], flash_miso};
          end else if (bit_q == BIT_W'(7)) begin
            bit_d   = '0;
            data_d  = shreg_q;
            busy_d  = 1'b0;
            state_d = S_VALID;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end

      S_VALID: begin
        sck_d = 1'b0;
        if (FLASH_continue) begin
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          state_d = S_READ;
        end
      end

      S_CS_HOLD: begin
        ncs_d  = 1'b1;
        sck_d  = 1'b0;
        busy_d = 1'b1;
        hold_d = hold_q + HOLD_W'(1);
        if (hold_q == HOLD_W'(CS_HOLD_CYC - 1)) begin
          hold_d  = '0;
          div_d   = '0;
          bit_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort beats any in-flight shift or continue; a partial byte never reaches FLASH_data
    if (abort) begin
      state_d = S_CS_HOLD;
      ncs_d   = 1'b1;
      sck_d   = 1'b0;
      mosi_d  = 1'b0;
      busy_d  = 1'b1;
      data_d  = data_q;
      div_d   = '0;
      bit_d   = '0;
      hold_d  = '0;
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Self-checking bench for spi_flash_reader with a behavioural SPI flash model.
// Honours FLASH_FAST_READ_EN when compiled with the same define as the design.
module tb_spi_flash_reader;

  localparam int unsigned CLK_DIV     = 2;
  localparam logic [15:0] ADDR_LO     = 16'h0;
  localparam int unsigned CS_HOLD_CYC = 4;
`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0]  OPC        = 8'h0B;
  localparam int unsigned DUMMY_BITS = 8;
`else
  localparam logic [7:0]  OPC        = 8'h03;
  localparam int unsigned DUMMY_BITS = 0;
`endif
  localparam int unsigned HDR       = 32 + DUMMY_BITS;
  localparam int unsigned FIRST_LAT = 1 + CLK_DIV + (HDR + 8) * 2 * CLK_DIV;
  localparam int unsigned NEXT_LAT  = 1 + 8 * 2 * CLK_DIV;
  localparam int unsigned BOUND     = 2000;

  logic       clk_in = 1'b0;
  logic       reset_n;
  logic       FLASH_enable;
  logic [7:0] FLASH_sector;
  logic       FLASH_continue;
  logic [7:0] FLASH_data;
  logic       FLASH_busy;
  logic       flash_ncs;
  logic       flash_sck;
  logic       flash_mosi;
  logic       flash_miso = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk_in = ~clk_in;

  spi_flash_reader #(
    .CLK_DIV    (CLK_DIV),
    .ADDR_LO    (ADDR_LO),
    .CS_HOLD_CYC(CS_HOLD_CYC)
  ) dut (
    .clk_in        (clk_in),
    .reset_n       (reset_n),
    .FLASH_enable  (FLASH_enable),
    .FLASH_sector  (FLASH_sector),
    .FLASH_continue(FLASH_continue),
    .FLASH_data    (FLASH_data),
    .FLASH_busy    (FLASH_busy),
    .flash_ncs     (flash_ncs),
    .flash_sck     (flash_sck),
    .flash_mosi    (flash_mosi),
    .flash_miso    (flash_miso)
  );

  // Flash model: 256-byte image mirrored across the address space, auto-incrementing reads
  logic [7:0]  mem [256];
  int unsigned rise_cnt   = 0;
  int unsigned tot_rise   = 0;
  int unsigned dummy_viol = 0;
  logic [31:0] cmd_cap    = '0;

  always @(posedge flash_sck or flash_ncs) begin
    if (flash_ncs !== 1'b0) begin
      rise_cnt = 0;
    end else if (flash_sck === 1'b1) begin
      if (rise_cnt < 32) cmd_cap = {cmd_cap[30:0], flash_mosi};
      else if (rise_cnt < HDR && flash_mosi !== 1'b0) dummy_viol++;
      rise_cnt++;
      tot_rise++;
    end
  end

  always @(negedge flash_sck) begin
    if (flash_ncs === 1'b0 && rise_cnt >= HDR) begin
      int unsigned k;
      logic [23:0] a;
      logic [7:0]  b;
      k = rise_cnt - HDR;
      a = cmd_cap[23:0] + 24'(k / 8);
      b = mem[a[7:0]];
      flash_miso = b[3'(7 - (k % 8))];
    end
  end

  // Pin monitor: mosi steady while sck high, and 0 whenever no command bit is on the wire
  logic mon_en = 1'b0;
  logic prev_sck = 1'b0, prev_mosi = 1'b0;
  int   mosi_viol = 0;
  always @(negedge clk_in) begin
    if (mon_en) begin
      if (flash_sck === 1'b1 && prev_sck === 1'b1 && flash_mosi !== prev_mosi) mosi_viol++;
      if (flash_ncs === 1'b1 && flash_mosi !== 1'b0) mosi_viol++;
      if (flash_ncs === 1'b0 && flash_sck === 1'b0 && rise_cnt >= 32 && flash_mosi !== 1'b0)
        mosi_viol++;
      prev_sck  = flash_sck;
      prev_mosi = flash_mosi;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [7:0] s, input int unsigned k);
    logic [23:0] a;
    a = {s, ADDR_LO} + 24'(k);
    return mem[a[7:0]];
  endfunction

  task automatic wait_valid(input int n0, output int n);
    n = n0;
    while (FLASH_busy !== 1'b0 && n < BOUND) begin
      @(negedge clk_in);
      n++;
    end
  endtask

  task automatic start_txn(input logic [7:0] s, input string tag);
    int n;
    @(negedge clk_in);
    FLASH_enable = 1'b1;
    FLASH_sector = s;
    @(negedge clk_in);
    check({tag, "_ncs_low"}, 32'(flash_ncs), 32'd0);
    FLASH_sector = ~s;
    wait_valid(1, n);
    check({tag, "_first_lat"}, 32'(n), 32'(FIRST_LAT));
    check({tag, "_cmd"}, cmd_cap, {OPC, s, ADDR_LO});
    check({tag, "_byte0"}, 32'(FLASH_data), 32'(exp_byte(s, 0)));
  endtask

  task automatic next_byte(input logic [7:0] s, input int unsigned k, input string tag);
    int n;
    @(negedge clk_in);
    FLASH_continue = 1'b1;
    @(negedge clk_in);
    FLASH_continue = 1'b0;
    check({tag, "_busy_c1"}, 32'(FLASH_busy), 32'd1);
    wait_valid(1, n);
    check({tag, "_lat"}, 32'(n), 32'(NEXT_LAT));
    check({tag, "_data"}, 32'(FLASH_data), 32'(exp_byte(s, k)));
  endtask

  initial begin
    int n, hi, g;
    int unsigned r0;
    logic [7:0] s;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    reset_n = 1'b0; FLASH_enable = 1'b0; FLASH_sector = 8'h00; FLASH_continue = 1'b0;

    // Reset values
    @(negedge clk_in);
    check("rst_ncs", 32'(flash_ncs), 32'd1);
    check("rst_sck", 32'(flash_sck), 32'd0);
    check("rst_mosi", 32'(flash_mosi), 32'd0);
    check("rst_busy", 32'(FLASH_busy), 32'd1);
    check("rst_data", 32'(FLASH_data), 32'hFF);
    @(negedge clk_in);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Basic read of sector 12 and a three-byte stream
    mem[0] = 8'hA5; mem[1] = 8'h01; mem[2] = 8'h02; mem[3] = 8'h03;
    start_txn(8'h12, "t2");
    next_byte(8'h12, 1, "t3_b1");
    next_byte(8'h12, 2, "t3_b2");
    next_byte(8'h12, 3, "t3_b3");

    // Continue during READ shifting is ignored
    @(negedge clk_in);
    FLASH_continue = 1'b1;
    @(negedge clk_in);
    FLASH_continue = 1'b0;
    repeat (5) @(negedge clk_in);
    FLASH_continue = 1'b1;
    @(negedge clk_in);
    FLASH_continue = 1'b0;
    wait_valid(7, n);
    check("t4_lat", 32'(n), 32'(NEXT_LAT));
    check("t4_data", 32'(FLASH_data), 32'(exp_byte(8'h12, 4)));
    r0 = tot_rise;
    repeat (40) @(negedge clk_in);
    check("t4_busy_held", 32'(FLASH_busy), 32'd0);
    check("t4_no_extra_sck", tot_rise, r0);
    check("t4_data_held", 32'(FLASH_data), 32'(exp_byte(8'h12, 4)));

    // Abort after 5 bits of a byte, re-enable during CS hold with a new sector
    r0 = tot_rise;
    @(negedge clk_in);
    FLASH_continue = 1'b1;
    @(negedge clk_in);
    FLASH_continue = 1'b0;
    g = 0;
    while (tot_rise < r0 + 5 && g < BOUND) begin
      @(negedge clk_in);
      g++;
    end
    check("t5_bit5_reached", 32'(tot_rise >= r0 + 5), 32'd1);
    FLASH_enable = 1'b0;
    @(negedge clk_in);
    check("t5_ncs_high", 32'(flash_ncs), 32'd1);
    check("t5_sck_low", 32'(flash_sck), 32'd0);
    check("t5_busy", 32'(FLASH_busy), 32'd1);
    check("t5_data_kept", 32'(FLASH_data), 32'(exp_byte(8'h12, 4)));
    FLASH_enable = 1'b1;
    FLASH_sector = 8'h3C;
    hi = 1;
    g  = 0;
    while (g < BOUND) begin
      @(negedge clk_in);
      g++;
      if (flash_ncs === 1'b1) hi++;
      else break;
    end
    FLASH_sector = 8'hC3;
    check("t5_ncs_high_cycles", 32'(hi), 32'(CS_HOLD_CYC + 1));
    wait_valid(1, n);
    check("t5_restart_lat", 32'(n), 32'(FIRST_LAT));
    check("t5_restart_cmd", cmd_cap, {OPC, 8'h3C, ADDR_LO});
    check("t5_restart_data", 32'(FLASH_data), 32'(exp_byte(8'h3C, 0)));

    // Reset held 3 cycles in the middle of a read
    @(negedge clk_in);
    FLASH_continue = 1'b1;
    @(negedge clk_in);
    FLASH_continue = 1'b0;
    repeat (10) @(negedge clk_in);
    reset_n = 1'b0;
    FLASH_enable = 1'b0;
    @(negedge clk_in);
    check("t1_ncs", 32'(flash_ncs), 32'd1);
    check("t1_sck", 32'(flash_sck), 32'd0);
    check("t1_busy", 32'(FLASH_busy), 32'd1);
    check("t1_data", 32'(FLASH_data), 32'hFF);
    repeat (2) @(negedge clk_in);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_in);
    check("t1_idle_ncs", 32'(flash_ncs), 32'd1);
    check("t1_idle_busy", 32'(FLASH_busy), 32'd1);

    // Randomized transactions against the model
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      s = 8'($urandom);
      start_txn(s, $sformatf("rnd%0d", t));
      for (int k = 1; k <= int'($urandom_range(2, 4)); k++) begin
        repeat ($urandom_range(0, 5)) @(negedge clk_in);
        next_byte(s, k, $sformatf("rnd%0d_b%0d", t, k));
      end
      @(negedge clk_in);
      FLASH_enable = 1'b0;
      repeat (8) @(negedge clk_in);
      check($sformatf("rnd%0d_end_ncs", t), 32'(flash_ncs), 32'd1);
    end

    check("mosi_rules", 32'(mosi_viol), 32'd0);
    check("dummy_mosi_zero", dummy_viol, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
